// File: rtl/lcd_text_buffer.sv
// Character-cell text memory for the LCD character generator.
// Host bytes arrive over valid/ready and are interpreted as printable
// characters or control codes; the LCD side reads one cell per cycle.
module lcd_text_buffer #(
    parameter int COLUMNS = 80,
    parameter int ROWS    = 30
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [6:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic [6:0] column,
    input  logic [5:0] row,
    output logic [6:0] character,
    output logic [6:0] cursor_column,
    output logic [5:0] cursor_row,
    output logic       busy
);

    typedef enum logic [1:0] {
        CLEAR_ALL,
        IDLE,
        CLEAR_LINE
    } state_t;

    localparam logic [6:0] LAST_COL = 7'(COLUMNS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
    localparam logic [6:0] ROWS_W   = 7'(ROWS);
    localparam logic [7:0] COLS_W   = 8'(COLUMNS);
    localparam logic [6:0] SPACE    = 7'h20;

    state_t     state, state_next;
    logic [5:0] top, top_next;
    logic [6:0] cur_col, cur_col_next;
    logic [5:0] cur_row, cur_row_next;
    logic [6:0] clr_col, clr_col_next;
    logic [5:0] clr_row, clr_row_next;
    logic       do_next_row;

    logic        wr_en;
    logic [12:0] wr_addr;
    logic [6:0]  wr_data;
    logic [12:0] rd_addr;
    logic        rd_in_range;

    logic [6:0] mem [0:8191];

    // Display row to physical row: the scroll offset rotates the rows so
    // scrolling never has to move any stored text.
    function automatic logic [5:0] phys_row(input logic [5:0] r, input logic [5:0] t);
        logic [6:0] s;
        s = {1'b0, r} + {1'b0, t};
        if (s >= ROWS_W)
            s = s - ROWS_W;
        return s[5:0];
    endfunction

    assign rd_addr     = {phys_row(row, top), column};
    assign rd_in_range = ({1'b0, column} < COLS_W) && ({1'b0, row} < ROWS_W);

    assign char_ready    = (state == IDLE);
    assign busy          = (state != IDLE);
    assign cursor_column = cur_col;
    assign cursor_row    = cur_row;

    // Next-state logic: clear sweeps, character handling, cursor and scroll.
    always_comb begin
        state_next   = state;
        top_next     = top;
        cur_col_next = cur_col;
        cur_row_next = cur_row;
        clr_col_next = clr_col;
        clr_row_next = clr_row;
        do_next_row  = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = {clr_row, clr_col};
        wr_data      = SPACE;

        case (state)
            CLEAR_ALL: begin
                wr_en = 1'b1;
                if (clr_col == LAST_COL) begin
                    clr_col_next = '0;
                    if (clr_row == LAST_ROW) begin
                        clr_row_next = '0;
                        state_next   = IDLE;
                    end else begin
                        clr_row_next = clr_row + 6'd1;
                    end
                end else begin
                    clr_col_next = clr_col + 7'd1;
                end
            end

            CLEAR_LINE: begin
                wr_en = 1'b1;
                if (clr_col == LAST_COL) begin
                    clr_col_next = '0;
                    state_next   = IDLE;
                end else begin
                    clr_col_next = clr_col + 7'd1;
                end
            end

            IDLE: begin
                if (char_valid) begin
                    if (char_data >= 7'h20 && char_data <= 7'h7E) begin
                        wr_en   = 1'b1;
                        wr_addr = {phys_row(cur_row, top), cur_col};
                        wr_data = char_data;
                        if (cur_col == LAST_COL) begin
                            cur_col_next = '0;
                            do_next_row  = 1'b1;
                        end else begin
                            cur_col_next = cur_col + 7'd1;
                        end
                    end else begin
                        case (char_data)
                            7'h0D: cur_col_next = '0;
                            7'h0A: begin
                                cur_col_next = '0;
                                do_next_row  = 1'b1;
                            end
                            7'h08: begin
                                if (cur_col != '0)
                                    cur_col_next = cur_col - 7'd1;
                            end
                            7'h0C: begin
                                top_next     = '0;
                                cur_col_next = '0;
                                cur_row_next = '0;
                                clr_col_next = '0;
                                clr_row_next = '0;
                                state_next   = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end

                    // Moving past the bottom line scrolls; the old top row
                    // becomes the new bottom line and gets blanked.
                    if (do_next_row) begin
                        if (cur_row != LAST_ROW) begin
                            cur_row_next = cur_row + 6'd1;
                        end else begin
                            top_next     = (top == LAST_ROW) ? 6'd0 : top + 6'd1;
                            clr_row_next = top;
                            clr_col_next = '0;
                            state_next   = CLEAR_LINE;
                        end
                    end
                end
            end

            default: state_next = CLEAR_ALL;
        endcase
    end

    // State, cursor, scroll offset and clear counters; reset restarts a full clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= CLEAR_ALL;
            top     <= '0;
            cur_col <= '0;
            cur_row <= '0;
            clr_col <= '0;
            clr_row <= '0;
        end else begin
            state   <= state_next;
            top     <= top_next;
            cur_col <= cur_col_next;
            cur_row <= cur_row_next;
            clr_col <= clr_col_next;
            clr_row <= clr_row_next;
        end
    end

    // Single write port shared by host characters and clear sweeps.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Registered read; cells outside the visible area read as a space.
    always_ff @(posedge clock) begin
        if (!reset_n)
            character <= SPACE;
        else if (rd_in_range)
            character <= mem[rd_addr];
        else
            character <= SPACE;
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Self-checking bench for lcd_text_buffer: a display-level screen model
// predicts read data, table vectors drive the cursor, hand sequences cover
// clears, scrolling and reset during a clear.
module tb_lcd_text_buffer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [6:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic [6:0] column;
    logic [5:0] row;
    logic [6:0] character;
    logic [6:0] cursor_column;
    logic [5:0] cursor_row;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [6:0] scr [30][80];
    int         mcol;
    int         mrow;

    typedef struct {
        logic [6:0] col;
        logic [5:0] row;
        logic [6:0] expected;
    } rd_t;

    rd_t sb_q[$];

    typedef struct {
        logic [6:0] code;
        logic [6:0] exp_col;
        logic [5:0] exp_row;
    } vec_t;

    typedef struct {
        int c;
        int r;
    } cell_t;

    vec_t  vecs[12];
    cell_t oor[6];

    lcd_text_buffer #(.COLUMNS(80), .ROWS(30)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .char_data     (char_data),
        .char_valid    (char_valid),
        .char_ready    (char_ready),
        .column        (column),
        .row           (row),
        .character     (character),
        .cursor_column (cursor_column),
        .cursor_row    (cursor_row),
        .busy          (busy)
    );

    // Free-running clock, 10 ns period.
    always #5 clock = ~clock;

    // Hard stop in case something never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkCursor(input string tag, input int c, input int r);
        checkOutput({tag, "_col"}, 32'(cursor_column), c);
        checkOutput({tag, "_row"}, 32'(cursor_row), r);
    endtask

    function automatic logic [6:0] modelRead(input int c, input int r);
        if (c >= 80 || r >= 30)
            return 7'h20;
        return scr[r][c];
    endfunction

    task automatic modelClearAll();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                scr[r][c] = 7'h20;
        mcol = 0;
        mrow = 0;
    endtask

    task automatic modelNextRow();
        if (mrow < 29) begin
            mrow++;
        end else begin
            for (int r = 0; r < 29; r++)
                for (int c = 0; c < 80; c++)
                    scr[r][c] = scr[r + 1][c];
            for (int c = 0; c < 80; c++)
                scr[29][c] = 7'h20;
        end
    endtask

    task automatic modelApply(input logic [6:0] code);
        if (code >= 7'h20 && code <= 7'h7E) begin
            scr[mrow][mcol] = code;
            if (mcol == 79) begin
                mcol = 0;
                modelNextRow();
            end else begin
                mcol++;
            end
        end else begin
            case (code)
                7'h0D: mcol = 0;
                7'h0A: begin
                    mcol = 0;
                    modelNextRow();
                end
                7'h08: if (mcol > 0) mcol--;
                7'h0C: modelClearAll();
                default: ;
            endcase
        end
    endtask

    // Present one character for one cycle; called on a falling edge.
    task automatic applyStimulus(input logic [6:0] code);
        checkOutput($sformatf("ready_for_0x%0h", code), 32'(char_ready), 1);
        char_data  = code;
        char_valid = 1'b1;
        @(negedge clock);
        modelApply(code);
    endtask

    // One read through the scoreboard: expectation queued at drive time,
    // compared one cycle later.
    task automatic readCell(input int c, input int r);
        rd_t e;
        column     = 7'(c);
        row        = 6'(r);
        e.col      = 7'(c);
        e.row      = 6'(r);
        e.expected = modelRead(c, r);
        sb_q.push_back(e);
        @(negedge clock);
        e = sb_q.pop_front();
        checkOutput($sformatf("read(%0d,%0d)", e.col, e.row), 32'(character), 32'(e.expected));
    endtask

    task automatic scanScreen();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                readCell(c, r);
    endtask

    // Count cycles with char_ready low (bounded), checking busy meanwhile.
    task automatic waitReady(input string tag, input int expected_cycles, input int limit);
        int n;
        int busy_bad;
        n = 0;
        busy_bad = 0;
        while (char_ready !== 1'b1 && n < limit) begin
            if (busy !== 1'b1)
                busy_bad++;
            n++;
            @(negedge clock);
        end
        checkOutput({tag, "_cycles"}, n, expected_cycles);
        checkOutput({tag, "_busy_low_cycles"}, busy_bad, 0);
    endtask

    initial begin
        vecs = '{
            '{7'h41, 7'd1, 6'd0},
            '{7'h42, 7'd2, 6'd0},
            '{7'h08, 7'd1, 6'd0},
            '{7'h0D, 7'd0, 6'd0},
            '{7'h08, 7'd0, 6'd0},
            '{7'h0A, 7'd0, 6'd1},
            '{7'h01, 7'd0, 6'd1},
            '{7'h7E, 7'd1, 6'd1},
            '{7'h7F, 7'd1, 6'd1},
            '{7'h20, 7'd2, 6'd1},
            '{7'h0D, 7'd0, 6'd1},
            '{7'h0A, 7'd0, 6'd2}
        };
        oor = '{'{100, 5}, '{3, 40}, '{80, 0}, '{0, 30}, '{127, 63}, '{79, 29}};

        reset_n    = 1'b0;
        char_valid = 1'b0;
        char_data  = 7'h00;
        column     = 7'd127;
        row        = 6'd63;
        modelClearAll();

        repeat (3) @(negedge clock);
        checkOutput("reset_ready", 32'(char_ready), 0);
        checkOutput("reset_busy", 32'(busy), 1);
        checkOutput("reset_character", 32'(character), 32'h20);
        checkCursor("reset", 0, 0);

        // Release reset with valid held high; nothing may be accepted.
        char_data  = 7'h41;
        char_valid = 1'b1;
        reset_n    = 1'b1;
        waitReady("clear_all", 2400, 3000);
        char_valid = 1'b0;
        checkCursor("after_clear_all", 0, 0);
        scanScreen();

        // Table-driven back-to-back characters and control codes.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].code);
            checkCursor($sformatf("vec%0d", i), 32'(vecs[i].exp_col), 32'(vecs[i].exp_row));
        end
        char_valid = 1'b0;
        readCell(0, 0);
        readCell(1, 0);
        readCell(2, 0);
        readCell(0, 1);
        readCell(1, 1);

        // Out-of-range reads return a space one cycle later.
        for (int i = 0; i < 6; i++)
            readCell(oor[i].c, oor[i].r);

        // Column wrap, then CR and BS at column 0.
        for (int i = 0; i < 80; i++)
            applyStimulus(7'(8'h21 + 8'(i)));
        checkCursor("wrap", 0, 3);
        applyStimulus(7'h0D);
        checkCursor("cr_after_wrap", 0, 3);
        applyStimulus(7'h08);
        checkCursor("bs_at_col0", 0, 3);
        char_valid = 1'b0;
        readCell(0, 2);
        readCell(40, 2);
        readCell(79, 2);
        readCell(0, 3);

        // Walk to the bottom line, mark it, then scroll.
        while (mrow < 29)
            applyStimulus(7'h0A);
        applyStimulus(7'h5A);
        checkCursor("bottom_mark", 1, 29);
        applyStimulus(7'h0A);
        char_valid = 1'b0;
        checkCursor("scroll", 0, 29);
        waitReady("clear_line", 80, 200);
        scanScreen();

        // Form feed restarts a full clear and homes the cursor.
        applyStimulus(7'h0C);
        char_valid = 1'b0;
        checkCursor("form_feed", 0, 0);
        waitReady("form_feed_clear", 2400, 3000);
        readCell(0, 0);
        readCell(79, 29);
        readCell(1, 1);

        // Reset in the middle of a line clear.
        while (mrow < 29)
            applyStimulus(7'h0A);
        applyStimulus(7'h0A);
        char_valid = 1'b0;
        repeat (40) @(negedge clock);
        checkOutput("mid_clear_line_ready", 32'(char_ready), 0);
        reset_n = 1'b0;
        @(negedge clock);
        checkOutput("mid_reset_busy", 32'(busy), 1);
        checkOutput("mid_reset_character", 32'(character), 32'h20);
        checkCursor("mid_reset", 0, 0);
        reset_n = 1'b1;
        modelClearAll();
        waitReady("reset_clear_all", 2400, 3000);
        checkCursor("after_reset_clear", 0, 0);
        applyStimulus(7'h41);
        applyStimulus(7'h42);
        char_valid = 1'b0;
        checkCursor("after_reset_text", 2, 0);
        readCell(0, 0);
        readCell(1, 0);
        readCell(2, 0);
        readCell(0, 29);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
